// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline: load-use bubbles, branch squashes,
// data-memory stalls with a sticky timeout halt, plus saturating stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int MAX_MEM_WAIT = 15,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rn_id,
   input  logic [4:0]       Ab_id,
   input  logic             use_rn_id,
   input  logic             use_ab_id,
   input  logic [4:0]       Rd_ex,
   input  logic             MemtoReg_ex,
   input  logic             RegWrite_ex,
   input  logic             BrTaken,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MEM_WAIT);
   localparam logic [4:0] ZERO_REG = 5'd31;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic              mem_timeout_reg, mem_timeout_next;
   logic [1:0][CNT_W-1:0] cnt_reg;
   logic [1:0]        cnt_inc;
   logic              load_use;
   logic              frozen;

   // X31 reads as zero, so a load targeting it can never create a dependency.
   assign load_use = MemtoReg_ex && RegWrite_ex && (Rd_ex != ZERO_REG) &&
                     ((use_rn_id && (Rn_id == Rd_ex)) || (use_ab_id && (Ab_id == Rd_ex)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= RUN;
         wait_cnt_reg    <= '0;
         mem_timeout_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         wait_cnt_reg    <= wait_cnt_next;
         mem_timeout_reg <= mem_timeout_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      wait_cnt_next    = wait_cnt_reg;
      mem_timeout_next = mem_timeout_reg;
      case (state_reg)
         RUN: begin
            if (mem_busy) begin
               state_next    = MEM_WAIT;
               wait_cnt_next = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (mem_busy) begin
               if (wait_cnt_reg == WAIT_MAX) begin
                  state_next       = HALT;
                  mem_timeout_next = 1'b1;
               end else begin
                  wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
               end
            end else begin
               state_next    = RUN;
               wait_cnt_next = '0;
            end
         end
         HALT: state_next = HALT;
         default: begin
            state_next    = RUN;
            wait_cnt_next = '0;
         end
      endcase
   end

   // RUN and a completing MEM_WAIT share the same hazard priority; only mem_busy
   // or HALT freezes the whole pipeline.
   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      idex_en    = 1'b1;
      idex_flush = 1'b0;
      exmem_en   = 1'b1;
      case (state_reg)
         RUN, MEM_WAIT: frozen = mem_busy;
         default:       frozen = 1'b1;
      endcase
      if (frozen) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
      end else if (BrTaken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   assign cnt_inc = {ifid_flush | idex_flush, ~pc_en};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (cnt_inc[i] && (cnt_reg[i] != {CNT_W{1'b1}})) begin
               cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
            end
         end
      end
   end

   assign stall_cnt   = cnt_reg[0];
   assign flush_cnt   = cnt_reg[1];
   assign mem_timeout = mem_timeout_reg;

endmodule
